// File: rtl/pstack_ctrl.sv
// Branch-command sequencer driving the predicate stack (push/comp/pop).
// Define PSTACK_CTRL_SKIP_EN to enable empty-arm skip jumps in RESOLVE.
module pstack_ctrl #(
  parameter int N_CORES = 4,
  parameter int DEPTH   = 4,
  parameter int PC_W    = 8,
  localparam int DW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [N_CORES-1:0] cmd_cond,
  input  logic [PC_W-1:0]    cmd_else_pc,
  input  logic [PC_W-1:0]    cmd_endif_pc,
  output logic [N_CORES-1:0] ps_d,
  output logic               ps_push,
  output logic               ps_comp,
  output logic               ps_pop,
  input  logic [N_CORES-1:0] ps_q,
  input  logic               ps_all_false,
  output logic [N_CORES-1:0] active_mask,
  output logic               jump_valid,
  output logic [PC_W-1:0]    jump_pc,
  output logic [DW-1:0]      depth,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_IF    = 2'b01;
  localparam logic [1:0] OP_ELSE  = 2'b10;
  localparam logic [1:0] OP_ENDIF = 2'b11;

  typedef enum logic [1:0] {
    IDLE, ISSUE, SETTLE, RESOLVE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]         op_q;
  logic [N_CORES-1:0] ps_d_q;
  logic [DW-1:0]      depth_q;
  logic               ovf_q;
  logic               unf_q;

  logic accept;
  logic is_if, is_else, is_endif;
  logic full, empty;

  assign accept   = cmd_valid && (state_q == IDLE);
  assign is_if    = (op_q == OP_IF);
  assign is_else  = (op_q == OP_ELSE);
  assign is_endif = (op_q == OP_ENDIF);
  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && cmd_op != OP_NOP)
                 state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Guarded strobes: overflow/underflow commands still walk the FSM.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    ps_push   = 1'b0;
    ps_comp   = 1'b0;
    ps_pop    = 1'b0;
    if (state_q == ISSUE) begin
      unique case (1'b1)
        is_if:    ps_push = !full;
        is_else:  ps_comp = !empty;
        is_endif: ps_pop  = !empty;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_NOP;
      ps_d_q  <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        if (cmd_op == OP_IF)
          ps_d_q <= cmd_cond & ps_q;
      end
      if (ps_push)
        depth_q <= depth_q + 1'b1;
      else if (ps_pop)
        depth_q <= depth_q - 1'b1;
      if (state_q == ISSUE && is_if && full)
        ovf_q <= 1'b1;
      if (state_q == ISSUE && !is_if && empty)
        unf_q <= 1'b1;
    end
  end

  assign ps_d          = ps_d_q;
  assign active_mask   = ps_q;
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

`ifdef PSTACK_CTRL_SKIP_EN
  logic [PC_W-1:0] else_pc_q;
  logic [PC_W-1:0] endif_pc_q;
  logic            ok_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      else_pc_q  <= '0;
      endif_pc_q <= '0;
      ok_q       <= 1'b0;
    end else begin
      if (accept) begin
        else_pc_q  <= cmd_else_pc;
        endif_pc_q <= cmd_endif_pc;
      end
      if (state_q == ISSUE)
        ok_q <= ps_push | ps_comp;
    end
  end

  assign jump_valid = (state_q == RESOLVE)
                    && ok_q && ps_all_false;
  assign jump_pc    = !jump_valid ? '0 :
                      is_if ? else_pc_q : endif_pc_q;
`else
  logic unused_skip;
  assign unused_skip = ^{ps_all_false, cmd_else_pc,
                         cmd_endif_pc};
  assign jump_valid  = 1'b0;
  assign jump_pc     = '0;
`endif

endmodule

// File: tb/tb_pstack_ctrl.sv
// Directed bench for pstack_ctrl with a behavioural predicate stack.
// Jump expectations follow PSTACK_CTRL_SKIP_EN.
module tb_pstack_ctrl;

`ifdef PSTACK_CTRL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_IF    = 2'b01;
  localparam logic [1:0] OP_ELSE  = 2'b10;
  localparam logic [1:0] OP_ENDIF = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = OP_NOP;
  logic [3:0] cmd_cond = '0;
  logic [7:0] cmd_else_pc = '0;
  logic [7:0] cmd_endif_pc = '0;
  logic [3:0] ps_d;
  logic       ps_push, ps_comp, ps_pop;
  logic [3:0] ps_q;
  logic       ps_all_false;
  logic [3:0] active_mask;
  logic       jump_valid;
  logic [7:0] jump_pc;
  logic [2:0] depth;
  logic       err_overflow, err_underflow;

  always #5 clk = ~clk;

  pstack_ctrl #(.N_CORES(4), .DEPTH(4), .PC_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cond(cmd_cond),
    .cmd_else_pc(cmd_else_pc),
    .cmd_endif_pc(cmd_endif_pc),
    .ps_d(ps_d), .ps_push(ps_push),
    .ps_comp(ps_comp), .ps_pop(ps_pop),
    .ps_q(ps_q), .ps_all_false(ps_all_false),
    .active_mask(active_mask),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .depth(depth),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  // Predicate stack: empty stack reads all lanes active.
  logic       ps_rst;
  logic [3:0] stk [0:7];
  int         sp;
  logic [3:0] parent;

  assign ps_rst = !reset;

  always_comb begin
    ps_q   = 4'hF;
    parent = 4'hF;
    if (sp > 0) ps_q = stk[sp-1];
    if (sp > 1) parent = stk[sp-2];
  end
  assign ps_all_false = (ps_q == 4'h0);

  always @(posedge clk or posedge ps_rst) begin
    if (ps_rst) sp <= 0;
    else if (ps_push && sp < 8) begin
      stk[sp] <= ps_d;
      sp <= sp + 1;
    end else if (ps_comp && sp > 0)
      stk[sp-1] <= ~stk[sp-1] & parent;
    else if (ps_pop && sp > 0)
      sp <= sp - 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  logic [1:0] r_op;
  int         r_push, r_comp, r_pop, r_jmp;
  int         r_pat, r_jat;
  logic [7:0] r_pc;
  logic [3:0] r_d;
  logic       r_rdy, r_rdy_end;

  task automatic run_cmd(input logic [1:0] op,
                         input logic [3:0] cond,
                         input logic [7:0] epc,
                         input logic [7:0] npc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_cond = cond;
    cmd_else_pc = epc;
    cmd_endif_pc = npc;
    @(posedge clk);
    #1;
    r_op = op;
    r_push = 0; r_comp = 0; r_pop = 0; r_jmp = 0;
    r_pat = -1; r_jat = -1;
    r_pc = '0; r_d = '0;
    r_rdy = 1'b0; r_rdy_end = 1'b0;
    if (op != OP_NOP) begin
      cmd_op = OP_ENDIF;
      cmd_cond = 4'h0;
      cmd_else_pc = 8'hEE;
      cmd_endif_pc = 8'hDD;
    end else cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ps_push) begin
        r_push++; r_d = ps_d; r_pat = i;
      end
      if (ps_comp) r_comp++;
      if (ps_pop) r_pop++;
      if (jump_valid) begin
        r_jmp++; r_pc = jump_pc; r_jat = i;
      end
      if (i == 0) r_rdy = cmd_ready;
      if (i == 2) cmd_valid = 1'b0;
      if (i == 3) r_rdy_end = cmd_ready;
    end
  endtask

  task automatic expect_cmd(input string tag,
                            input int e_push,
                            input int e_comp,
                            input int e_pop,
                            input int e_jmp,
                            input logic [7:0] e_pc,
                            input logic [3:0] e_d,
                            input int e_depth,
                            input logic [3:0] e_mask);
    int ej;
    ej = SKIP ? e_jmp : 0;
    chk({tag, " push"}, r_push, e_push);
    chk({tag, " comp"}, r_comp, e_comp);
    chk({tag, " pop"}, r_pop, e_pop);
    if (e_push != 0) begin
      chk({tag, " ps_d"}, r_d, e_d);
      chk({tag, " push_cyc"}, r_pat, 0);
    end
    chk({tag, " jumps"}, r_jmp, ej);
    if (ej != 0) begin
      chk({tag, " jump_pc"}, r_pc, e_pc);
      chk({tag, " jump_cyc"}, r_jat, 2);
    end
    chk({tag, " depth"}, depth, e_depth);
    chk({tag, " mask"}, active_mask, e_mask);
    chk({tag, " ready"}, {r_rdy, r_rdy_end},
        (r_op == OP_NOP) ? 2'b11 : 2'b01);
  endtask

  int quiet;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst ready", cmd_ready, 1);
    chk("rst strobes", {ps_push, ps_comp, ps_pop}, 0);
    chk("rst ps_d", ps_d, 0);
    chk("rst depth", depth, 0);
    chk("rst errs", {err_overflow, err_underflow}, 0);
    chk("rst jump", {jump_valid, jump_pc}, 0);
    reset = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      quiet += int'(ps_push) + int'(ps_comp)
             + int'(ps_pop) + int'(jump_valid);
    end
    chk("idle quiet", quiet, 0);

    run_cmd(OP_NOP, 4'hF, 8'h11, 8'h12);
    expect_cmd("nop", 0, 0, 0, 0, 8'h0, 4'h0, 0, 4'hF);

    run_cmd(OP_IF, 4'b1010, 8'h10, 8'h30);
    expect_cmd("if1", 1, 0, 0, 0, 8'h0, 4'hA, 1, 4'hA);
    run_cmd(OP_IF, 4'b0101, 8'h20, 8'h31);
    expect_cmd("if2", 1, 0, 0, 1, 8'h20, 4'h0, 2, 4'h0);
    run_cmd(OP_IF, 4'b1111, 8'h21, 8'h32);
    expect_cmd("if3", 1, 0, 0, 1, 8'h21, 4'h0, 3, 4'h0);
    run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h33);
    expect_cmd("endif3", 0, 0, 1, 0, 8'h0, 4'h0, 2, 4'h0);
    run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h34);
    expect_cmd("endif2", 0, 0, 1, 0, 8'h0, 4'h0, 1, 4'hA);
    run_cmd(OP_ELSE, 4'h0, 8'h0, 8'h40);
    expect_cmd("else1", 0, 1, 0, 0, 8'h0, 4'h0, 1, 4'h5);
    run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h35);
    expect_cmd("endif1", 0, 0, 1, 0, 8'h0, 4'h0, 0, 4'hF);

    run_cmd(OP_IF, 4'hF, 8'h50, 8'h40);
    expect_cmd("if_all", 1, 0, 0, 0, 8'h0, 4'hF, 1, 4'hF);
    run_cmd(OP_ELSE, 4'h0, 8'h0, 8'h40);
    expect_cmd("else_skip", 0, 1, 0, 1, 8'h40, 4'h0, 1, 4'h0);
    run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h0);
    expect_cmd("endif_a", 0, 0, 1, 0, 8'h0, 4'h0, 0, 4'hF);
    chk("errs clean", {err_overflow, err_underflow}, 0);

    for (int k = 1; k <= 3; k++) begin
      run_cmd(OP_IF, 4'hF, 8'h60, 8'h61);
      expect_cmd("nest", 1, 0, 0, 0, 8'h0, 4'hF, k, 4'hF);
    end
    run_cmd(OP_IF, 4'h0, 8'h24, 8'h25);
    expect_cmd("nest4", 1, 0, 0, 1, 8'h24, 4'h0, 4, 4'h0);
    run_cmd(OP_IF, 4'hF, 8'h99, 8'h98);
    expect_cmd("ovf", 0, 0, 0, 0, 8'h0, 4'h0, 4, 4'h0);
    chk("ovf flag", err_overflow, 1);
    chk("ovf no unf", err_underflow, 0);

    for (int k = 3; k >= 0; k--) begin
      run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h0);
      expect_cmd("unnest", 0, 0, 1, 0, 8'h0, 4'h0, k, 4'hF);
    end
    chk("pre unf", err_underflow, 0);
    run_cmd(OP_ENDIF, 4'h0, 8'h0, 8'h0);
    expect_cmd("unf_endif", 0, 0, 0, 0, 8'h0, 4'h0, 0, 4'hF);
    chk("unf flag", err_underflow, 1);
    run_cmd(OP_ELSE, 4'h0, 8'h0, 8'h77);
    expect_cmd("unf_else", 0, 0, 0, 0, 8'h0, 4'h0, 0, 4'hF);

    run_cmd(OP_IF, 4'b0110, 8'h70, 8'h71);
    expect_cmd("post_err", 1, 0, 0, 0, 8'h0, 4'h6, 1, 4'h6);
    chk("sticky", {err_overflow, err_underflow}, 2'b11);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = OP_IF;
    cmd_cond = 4'h0;
    cmd_else_pc = 8'h66;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("abort pre push", ps_push, 1);
    reset = 1'b0;
    #1;
    chk("abort push", ps_push, 0);
    chk("abort depth", depth, 0);
    chk("abort ready", cmd_ready, 1);
    chk("abort errs", {err_overflow, err_underflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      quiet += int'(ps_push) + int'(ps_comp)
             + int'(ps_pop) + int'(jump_valid);
    end
    chk("abort quiet", quiet, 0);
    chk("abort idle", cmd_ready, 1);
    chk("abort mask", active_mask, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
